// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
package bus_sched_pkg;

   // Width of the destination ID field at the top of every packet
   localparam int unsigned ID_W      = 8;
   // Largest supported port count; sizes the destination-mask helper
   localparam int unsigned MAX_DRVRS = 16;
   // Source index width able to hold any port number up to MAX_DRVRS-1
   localparam int unsigned SRC_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      XFER = 2'd2,
      GAP  = 2'd3
   } sched_state_e;

   // Destination ports for a packet: everyone but the sender on broadcast,
   // one port for a valid foreign ID, nobody for out-of-range or self-addressed.
   // Broadcast is tested first so it wins even when it aliases a port number.
   function automatic logic [MAX_DRVRS-1:0] dest_mask(
      input logic [ID_W-1:0]  id,
      input logic [SRC_W-1:0] src,
      input int unsigned      drvrs,
      input logic [ID_W-1:0]  broadcast
   );
      logic [MAX_DRVRS-1:0] mask;
      mask = '0;
      if (id == broadcast) begin
         for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
            mask[i] = (i < drvrs) && (i != 32'(src));
         end
      end else if ((32'(id) < drvrs) && (id != ID_W'(src))) begin
         mask[id[SRC_W-1:0]] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt_onehot,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 any
);

   localparam int unsigned IDX_W = $clog2(N);

   logic [IDX_W-1:0] w_cand;

   // Walk the requests starting at ptr and keep the first one found
   always_comb begin
      // NOTE: every output gets a default before the search so no latch is inferred.
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      w_cand     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = IDX_W'((32'(ptr) + k) % N);
         if (!any && req[w_cand]) begin
            any                = 1'b1;
            gnt_idx            = w_cand;
            gnt_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for the shared packet bus: pops one pending source,
// decodes its destination and pushes the packet, with a turnaround gap.
module bus_rr_scheduler
   import bus_sched_pkg::*;
#(
   parameter int unsigned      drvrs     = 4,
   parameter int unsigned      pckg_sz   = 16,
   parameter logic [ID_W-1:0]  broadcast = {ID_W{1'b1}},
   parameter int unsigned      CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         D_push,
   output logic                       busy,
   output logic [CNT_W-1:0]           pkt_cnt,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam int unsigned IDX_W = $clog2(drvrs);

   sched_state_e         r_state;
   sched_state_e         w_next_state;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [pckg_sz-1:0]   r_data_q;
   logic [IDX_W-1:0]     r_src_q;
   logic [drvrs-1:0]     r_mask;
   logic [drvrs-1:0]     r_pop;
   logic [drvrs-1:0]     r_push;
   logic [pckg_sz-1:0]   r_d_push;
   logic                 r_busy;
   logic [CNT_W-1:0]     r_pkt_cnt;
   logic [CNT_W-1:0]     r_drop_cnt;

   logic [drvrs-1:0]     w_gnt_onehot;
   logic [IDX_W-1:0]     w_gnt_idx;
   logic                 w_any;
   logic [IDX_W-1:0]     w_next_ptr;
   logic [pckg_sz-1:0]   w_gnt_data;
   logic [drvrs-1:0]     w_dest_mask;

   rr_arbiter #(
      .N (drvrs)
   ) u_arb (
      .req        (pndng),
      .ptr        (r_rr_ptr),
      .gnt_onehot (w_gnt_onehot),
      .gnt_idx    (w_gnt_idx),
      .any        (w_any)
   );

   // The pointer moves just past the winner so it becomes lowest priority
   assign w_next_ptr  = (32'(w_gnt_idx) == drvrs - 1) ? '0 : w_gnt_idx + IDX_W'(1);
   assign w_dest_mask = drvrs'(dest_mask(r_data_q[pckg_sz-1 -: ID_W], SRC_W'(r_src_q),
                                         drvrs, broadcast));

   // Select the winning source's head packet
   always_comb begin
      w_gnt_data = '0;
      for (int unsigned i = 0; i < drvrs; i++) begin
         if (w_gnt_onehot[i]) w_gnt_data = D_pop[i*pckg_sz +: pckg_sz];
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic: a fixed four-beat cycle once a source is pending
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next_state = POP;
         POP:     w_next_state = XFER;
         XFER:    w_next_state = GAP;
         GAP:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Registered datapath: grant capture, destination decode, push and statistics
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: the packet holding registers are reset as well, so D_push is never X.
      if (!reset) begin
         r_rr_ptr   <= '0;
         r_data_q   <= '0;
         r_src_q    <= '0;
         r_mask     <= '0;
         r_pop      <= '0;
         r_push     <= '0;
         r_d_push   <= '0;
         r_busy     <= 1'b0;
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_pop  <= '0;
         r_push <= '0;
         r_busy <= (w_next_state != IDLE);
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_pop    <= w_gnt_onehot;
                  r_data_q <= w_gnt_data;
                  r_src_q  <= w_gnt_idx;
                  r_rr_ptr <= w_next_ptr;
               end
            end
            POP: begin
               r_mask <= w_dest_mask;
            end
            XFER: begin
               if (r_mask != '0) begin
                  r_push   <= r_mask;
                  r_d_push <= r_data_q;
                  if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
               end else begin
                  if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
               end
            end
            default: begin
               // GAP: bus turnaround, D_push keeps its last value
            end
         endcase
      end
   end

   assign pop      = r_pop;
   assign push     = r_push;
   assign D_push   = r_d_push;
   assign busy     = r_busy;
   assign pkt_cnt  = r_pkt_cnt;
   assign drop_cnt = r_drop_cnt;

endmodule
